// File: rtl/mc_pkg.sv
// mc_pkg: shared encodings for the multicycle control unit (opcodes,
// FSM states, decoded instruction classes and datapath select codes).
package mc_pkg;

    // Supported RV32 base opcodes (inst[6:0])
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    // Controller states, also exported on the debug state port
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd5
    } state_t;

    // Instruction classes produced by the opcode decoder
    typedef enum logic [2:0] {
        CLS_R      = 3'd0,
        CLS_I      = 3'd1,
        CLS_LOAD   = 3'd2,
        CLS_STORE  = 3'd3,
        CLS_BRANCH = 3'd4,
        CLS_JAL    = 3'd5,
        CLS_JALR   = 3'd6,
        CLS_LUI    = 3'd7
    } class_t;

    // Next-PC select
    localparam logic [1:0] NPC_PC4    = 2'd0;
    localparam logic [1:0] NPC_BRANCH = 2'd1;
    localparam logic [1:0] NPC_JAL    = 2'd2;
    localparam logic [1:0] NPC_JALR   = 2'd3;

    // Immediate format select
    localparam logic [2:0] SEXT_I = 3'd0;
    localparam logic [2:0] SEXT_S = 3'd1;
    localparam logic [2:0] SEXT_B = 3'd2;
    localparam logic [2:0] SEXT_U = 3'd3;
    localparam logic [2:0] SEXT_J = 3'd4;

    // Writeback source select
    localparam logic [1:0] WD_ALU_C    = 2'd0;
    localparam logic [1:0] WD_DRAM_RD  = 2'd1;
    localparam logic [1:0] WD_NPC_PC4  = 2'd2;
    localparam logic [1:0] WD_SEXT_EXT = 2'd3;

    // Only register-register ALU ops and branch compares take rd2 as ALU B
    function automatic logic uses_imm_operand(input class_t cls);
        return !((cls == CLS_R) || (cls == CLS_BRANCH));
    endfunction

endpackage

// File: rtl/mc_dec.sv
// mc_dec: combinational opcode decoder giving instruction class,
// legality, writeback source and immediate format.
module mc_dec
    import mc_pkg::*;
(
    input  logic [6:0] opcode,
    output class_t     op_class,
    output logic       legal,
    output logic [1:0] wd_sel,
    output logic [2:0] sext_op
);

    // Map the opcode onto its class and the per-class datapath selects
    always_comb begin
        op_class = CLS_R;
        legal    = 1'b1;
        wd_sel   = WD_ALU_C;
        sext_op  = SEXT_I;
        case (opcode)
            OP_R: begin
                op_class = CLS_R;
            end
            OP_I: begin
                op_class = CLS_I;
            end
            OP_LOAD: begin
                op_class = CLS_LOAD;
                wd_sel   = WD_DRAM_RD;
            end
            OP_STORE: begin
                op_class = CLS_STORE;
                sext_op  = SEXT_S;
            end
            OP_BRANCH: begin
                op_class = CLS_BRANCH;
                sext_op  = SEXT_B;
            end
            OP_JAL: begin
                op_class = CLS_JAL;
                wd_sel   = WD_NPC_PC4;
                sext_op  = SEXT_J;
            end
            OP_JALR: begin
                op_class = CLS_JALR;
                wd_sel   = WD_NPC_PC4;
            end
            OP_LUI: begin
                op_class = CLS_LUI;
                wd_sel   = WD_SEXT_EXT;
                sext_op  = SEXT_U;
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multicycle RV32 subset controller. Sequences fetch, decode,
// execute, memory and writeback with handshaked instruction/data memory
// and traps permanently on an unsupported opcode until reset.
module mc_ctrl
    import mc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst,
    input  logic        br_taken,
    output logic        imem_req,
    input  logic        imem_ack,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  npc_op,
    output logic [2:0]  sext_op,
    output logic        alu_b_sel,
    output logic        rf_we,
    output logic [1:0]  wd_sel,
    output logic        illegal,
    output logic [2:0]  state
);

    state_t     cur_state;
    state_t     next_state;
    class_t     op_class;
    logic       op_legal;
    logic [1:0] dec_wd_sel;
    logic [2:0] dec_sext_op;
    logic       illegal_q;
    logic       rd_nonzero;
    logic       unused_inst_bits;

    // Only opcode and rd fields matter to the controller
    assign unused_inst_bits = ^inst[31:12];
    assign rd_nonzero       = (inst[11:7] != 5'd0);

    mc_dec u_dec (
        .opcode   (inst[6:0]),
        .op_class (op_class),
        .legal    (op_legal),
        .wd_sel   (dec_wd_sel),
        .sext_op  (dec_sext_op)
    );

    // State register; reset abandons whatever access is in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= ST_FETCH;
        end else begin
            cur_state <= next_state;
        end
    end

    // Sticky trap flag, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
        end else if (next_state == ST_TRAP) begin
            illegal_q <= 1'b1;
        end
    end

    // Next-state: handshakes advance FETCH/MEM, the class picks the path
    always_comb begin
        next_state = cur_state;
        case (cur_state)
            ST_FETCH: begin
                if (imem_ack) begin
                    next_state = ST_DECODE;
                end
            end
            ST_DECODE: begin
                next_state = op_legal ? ST_EXEC : ST_TRAP;
            end
            ST_EXEC: begin
                case (op_class)
                    CLS_LOAD, CLS_STORE: next_state = ST_MEM;
                    CLS_BRANCH:          next_state = ST_FETCH;
                    default:             next_state = ST_WB;
                endcase
            end
            ST_MEM: begin
                if (dmem_ack) begin
                    next_state = (op_class == CLS_LOAD) ? ST_WB : ST_FETCH;
                end
            end
            ST_WB: begin
                next_state = ST_FETCH;
            end
            ST_TRAP: begin
                next_state = ST_TRAP;
            end
            default: begin
                next_state = ST_FETCH;
            end
        endcase
    end

    // Outputs from state and instruction; everything held quiet in reset
    always_comb begin
        imem_req  = 1'b0;
        ir_we     = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        pc_we     = 1'b0;
        rf_we     = 1'b0;
        npc_op    = NPC_PC4;
        sext_op   = SEXT_I;
        alu_b_sel = 1'b0;
        wd_sel    = WD_ALU_C;
        if (rst_n) begin
            case (cur_state)
                ST_FETCH: begin
                    imem_req = 1'b1;
                    ir_we    = imem_ack;
                end
                ST_DECODE: begin
                    sext_op = dec_sext_op;
                end
                ST_EXEC: begin
                    sext_op   = dec_sext_op;
                    alu_b_sel = uses_imm_operand(op_class);
                    if (op_class == CLS_BRANCH) begin
                        pc_we  = 1'b1;
                        npc_op = br_taken ? NPC_BRANCH : NPC_PC4;
                    end
                end
                ST_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = (op_class == CLS_STORE);
                    if ((op_class == CLS_STORE) && dmem_ack) begin
                        pc_we = 1'b1;
                    end
                end
                ST_WB: begin
                    pc_we  = 1'b1;
                    rf_we  = rd_nonzero;
                    wd_sel = dec_wd_sel;
                    if (op_class == CLS_JAL) begin
                        npc_op = NPC_JAL;
                    end else if (op_class == CLS_JALR) begin
                        npc_op = NPC_JALR;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign illegal = illegal_q;
    assign state   = cur_state;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed bench for mc_ctrl. Each instruction task builds the
// cycle-by-cycle expected outputs from the instruction table and pushes
// them to a queue; one compare process checks the DUT every cycle.
module tb_mc_ctrl;
    import mc_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [31:0] inst;
    logic        br_taken;
    logic        imem_req;
    logic        imem_ack;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack;
    logic        ir_we;
    logic        pc_we;
    logic [1:0]  npc_op;
    logic [2:0]  sext_op;
    logic        alu_b_sel;
    logic        rf_we;
    logic [1:0]  wd_sel;
    logic        illegal;
    logic [2:0]  state;

    typedef struct packed {
        logic [2:0] st;
        logic       imem_req;
        logic       ir_we;
        logic       dmem_req;
        logic       dmem_we;
        logic       pc_we;
        logic       rf_we;
        logic       alu_b_sel;
        logic       illegal;
        logic       sext_chk;
        logic [1:0] npc_op;
        logic [1:0] wd_sel;
        logic [2:0] sext_op;
    } exp_t;

    exp_t exp_q[$];
    exp_t chk_e;

    int checks          = 0;
    int errors          = 0;
    int cycle_no        = 0;
    int start_cycle     = 0;
    int last_pc_we_cyc  = -100;
    int pc_we_count     = 0;
    int rf_we_count     = 0;
    int dmem_req_count  = 0;
    int snap_rf;
    int snap_pc;
    int snap_dm;

    mc_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .inst      (inst),
        .br_taken  (br_taken),
        .imem_req  (imem_req),
        .imem_ack  (imem_ack),
        .dmem_req  (dmem_req),
        .dmem_we   (dmem_we),
        .dmem_ack  (dmem_ack),
        .ir_we     (ir_we),
        .pc_we     (pc_we),
        .npc_op    (npc_op),
        .sext_op   (sext_op),
        .alu_b_sel (alu_b_sel),
        .rf_we     (rf_we),
        .wd_sel    (wd_sel),
        .illegal   (illegal),
        .state     (state)
    );

    // Free-running clock, period 10
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %0d expected %0d",
                     name, cycle_no, actual, expected);
        end
    endtask

    function automatic exp_t idle(input logic [2:0] st);
        exp_t e;
        e    = '0;
        e.st = st;
        return e;
    endfunction

    // Compare process: every cycle that has an expectation is checked
    always @(negedge clk) begin
        #2;
        if (exp_q.size() > 0) begin
            chk_e = exp_q.pop_front();
            check_output("state",     32'(state),     32'(chk_e.st));
            check_output("imem_req",  32'(imem_req),  32'(chk_e.imem_req));
            check_output("ir_we",     32'(ir_we),     32'(chk_e.ir_we));
            check_output("dmem_req",  32'(dmem_req),  32'(chk_e.dmem_req));
            check_output("dmem_we",   32'(dmem_we),   32'(chk_e.dmem_we));
            check_output("pc_we",     32'(pc_we),     32'(chk_e.pc_we));
            check_output("rf_we",     32'(rf_we),     32'(chk_e.rf_we));
            check_output("alu_b_sel", 32'(alu_b_sel), 32'(chk_e.alu_b_sel));
            check_output("illegal",   32'(illegal),   32'(chk_e.illegal));
            check_output("npc_op",    32'(npc_op),    32'(chk_e.npc_op));
            check_output("wd_sel",    32'(wd_sel),    32'(chk_e.wd_sel));
            if (chk_e.sext_chk) begin
                check_output("sext_op", 32'(sext_op), 32'(chk_e.sext_op));
            end
            if (pc_we) begin
                pc_we_count++;
                last_pc_we_cyc = cycle_no;
            end
            if (rf_we) rf_we_count++;
            if (dmem_req) dmem_req_count++;
            cycle_no++;
        end
    end

    // Hold reset for n cycles; all outputs must be quiet, acks are noise
    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst_n    = 1'b0;
            imem_ack = 1'b1;
            dmem_ack = 1'b1;
            br_taken = 1'b1;
            exp_q.push_back(idle(ST_FETCH));
        end
    endtask

    // Run one instruction through the controller, releasing reset if held.
    // abort_mem >= 0 stops driving after that many MEM cycles.
    task automatic apply_stimulus(input logic [31:0] word, input int fetch_wait,
                                  input int mem_wait, input logic taken,
                                  input int abort_mem);
        exp_t       e;
        logic [6:0] opc;
        logic       is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, legal;
        logic [2:0] fmt;
        logic [1:0] wsel;
        opc     = word[6:0];
        is_r    = (opc == 7'b0110011);
        is_i    = (opc == 7'b0010011);
        is_ld   = (opc == 7'b0000011);
        is_st   = (opc == 7'b0100011);
        is_br   = (opc == 7'b1100011);
        is_jal  = (opc == 7'b1101111);
        is_jalr = (opc == 7'b1100111);
        is_lui  = (opc == 7'b0110111);
        legal   = is_r | is_i | is_ld | is_st | is_br | is_jal | is_jalr | is_lui;
        fmt     = is_st ? 3'd1 : is_br ? 3'd2 : is_lui ? 3'd3 : is_jal ? 3'd4 : 3'd0;
        wsel    = is_ld ? 2'd1 : (is_jal | is_jalr) ? 2'd2 : is_lui ? 2'd3 : 2'd0;

        // FETCH with fetch_wait wait states, then the ack cycle
        for (int i = 0; i <= fetch_wait; i++) begin
            @(negedge clk);
            if (i == 0) start_cycle = cycle_no;
            rst_n      = 1'b1;
            imem_ack   = (i == fetch_wait);
            dmem_ack   = 1'b1;
            br_taken   = 1'b0;
            e          = idle(ST_FETCH);
            e.imem_req = 1'b1;
            e.ir_we    = (i == fetch_wait);
            exp_q.push_back(e);
        end

        // DECODE: the loaded instruction register presents the new word
        @(negedge clk);
        inst       = word;
        imem_ack   = 1'b0;
        dmem_ack   = 1'b1;
        e          = idle(ST_DECODE);
        e.sext_chk = 1'b1;
        e.sext_op  = fmt;
        exp_q.push_back(e);

        if (!legal) begin
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                imem_ack  = 1'b1;
                dmem_ack  = 1'b1;
                e         = idle(ST_TRAP);
                e.illegal = 1'b1;
                exp_q.push_back(e);
            end
            #3;
            return;
        end

        // EXEC
        @(negedge clk);
        imem_ack    = 1'b1;
        dmem_ack    = 1'b1;
        br_taken    = taken;
        e           = idle(ST_EXEC);
        e.alu_b_sel = !(is_r | is_br);
        if (is_br) begin
            e.pc_we  = 1'b1;
            e.npc_op = taken ? 2'd1 : 2'd0;
        end
        exp_q.push_back(e);
        if (is_br) begin
            #3;
            return;
        end

        // MEM with mem_wait wait states
        if (is_ld | is_st) begin
            for (int i = 0; i <= mem_wait; i++) begin
                if (i == abort_mem) begin
                    #3;
                    return;
                end
                @(negedge clk);
                imem_ack   = 1'b1;
                dmem_ack   = (i == mem_wait);
                br_taken   = 1'b1;
                e          = idle(ST_MEM);
                e.dmem_req = 1'b1;
                e.dmem_we  = is_st;
                e.pc_we    = is_st && (i == mem_wait);
                exp_q.push_back(e);
            end
            if (is_st) begin
                #3;
                return;
            end
        end

        // WB
        @(negedge clk);
        imem_ack = 1'b1;
        dmem_ack = 1'b1;
        e        = idle(ST_WB);
        e.pc_we  = 1'b1;
        e.rf_we  = (word[11:7] != 5'd0);
        e.wd_sel = wsel;
        e.npc_op = is_jal ? 2'd2 : is_jalr ? 2'd3 : 2'd0;
        exp_q.push_back(e);
        #3;
    endtask

    task automatic snapshot();
        snap_rf = rf_we_count;
        snap_pc = pc_we_count;
        snap_dm = dmem_req_count;
    endtask

    // Directed program
    initial begin
        rst_n    = 1'b0;
        inst     = 32'h0000_0013;
        br_taken = 1'b0;
        imem_ack = 1'b0;
        dmem_ack = 1'b0;

        do_reset(2);

        // add x3,x1,x2 with zero-wait fetch
        snapshot();
        apply_stimulus(32'h002081B3, 0, 0, 1'b0, -1);
        check_output("add_latency", 32'(last_pc_we_cyc - start_cycle + 1), 4);
        check_output("add_rf_pulses", 32'(rf_we_count - snap_rf), 1);

        // lw x5,4(x0) with 2 fetch waits and 3 data waits
        snapshot();
        apply_stimulus(32'h00402283, 2, 3, 1'b0, -1);
        check_output("lw_dmem_req_cycles", 32'(dmem_req_count - snap_dm), 4);
        check_output("lw_latency", 32'(last_pc_we_cyc - start_cycle + 1), 10);
        check_output("lw_rf_pulses", 32'(rf_we_count - snap_rf), 1);

        // beq x1,x2,8 taken, then not taken
        snapshot();
        apply_stimulus(32'h00208463, 0, 0, 1'b1, -1);
        check_output("beq_t_latency", 32'(last_pc_we_cyc - start_cycle + 1), 3);
        apply_stimulus(32'h00208463, 0, 0, 1'b0, -1);
        check_output("beq_nt_latency", 32'(last_pc_we_cyc - start_cycle + 1), 3);
        check_output("beq_rf_pulses", 32'(rf_we_count - snap_rf), 0);

        // addi x0,x0,1 reaches WB without writing the register file
        snapshot();
        apply_stimulus(32'h00100013, 0, 0, 1'b0, -1);
        check_output("addi_x0_latency", 32'(last_pc_we_cyc - start_cycle + 1), 4);
        check_output("addi_x0_rf_pulses", 32'(rf_we_count - snap_rf), 0);

        // sw x5,8(x0) with one data wait
        snapshot();
        apply_stimulus(32'h00502423, 0, 1, 1'b0, -1);
        check_output("sw_latency", 32'(last_pc_we_cyc - start_cycle + 1), 5);
        check_output("sw_rf_pulses", 32'(rf_we_count - snap_rf), 0);

        // jal x1,16 / jalr x1,0(x5) / lui x7,0x12345
        apply_stimulus(32'h010000EF, 1, 0, 1'b0, -1);
        check_output("jal_latency", 32'(last_pc_we_cyc - start_cycle + 1), 5);
        apply_stimulus(32'h000280E7, 0, 0, 1'b0, -1);
        check_output("jalr_latency", 32'(last_pc_we_cyc - start_cycle + 1), 4);
        apply_stimulus(32'h123453B7, 0, 0, 1'b0, -1);
        check_output("lui_latency", 32'(last_pc_we_cyc - start_cycle + 1), 4);

        // sw aborted by reset after two MEM cycles: no pc_we may follow
        snapshot();
        apply_stimulus(32'h00502423, 0, 20, 1'b0, 2);
        do_reset(2);
        check_output("abort_pc_pulses", 32'(pc_we_count - snap_pc), 0);
        apply_stimulus(32'h002081B3, 0, 0, 1'b0, -1);
        check_output("post_abort_latency", 32'(last_pc_we_cyc - start_cycle + 1), 4);

        // Unsupported opcode traps; reset recovers with an immediate fetch
        snapshot();
        apply_stimulus(32'h0000007F, 0, 0, 1'b0, -1);
        check_output("trap_illegal", 32'(illegal), 1);
        check_output("trap_pc_pulses", 32'(pc_we_count - snap_pc), 0);
        do_reset(1);
        apply_stimulus(32'h002081B3, 0, 0, 1'b0, -1);
        check_output("recover_illegal", 32'(illegal), 0);

        @(negedge clk);
        imem_ack = 1'b0;
        dmem_ack = 1'b0;
        #3;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
